key_step_controller: RTL and testbench

- Sequences CPU execution from DE0 pushbuttons: free-run, stop, single-step and halt modes.
- Each raw key is synchronised and debounced, then converted to a one-cycle press event.
- A 4-state FSM drives the CPU clock-enable.
- Sits in the DE0 top level between the board keys and the CPU core's enable input.

---
 rtl/key_step_controller_pkg.sv | 16 +
 rtl/key_step_controller_debouncer.sv | 53 +++++
 rtl/key_step_controller.sv | 88 ++++++++
 tb/tb_key_step_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/key_step_controller_pkg.sv
// Shared types and constants for the pushbutton-driven CPU step controller.
// The optional instruction counter is built only when KEY_STEP_CNT_EN is defined.
package key_step_controller_pkg;

  typedef logic [1:0] mode_t;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/key_step_controller_debouncer.sv
// Synchronises and debounces one active-low pushbutton.
// Emits a one-cycle pulse when the key is accepted as pressed.
module key_debouncer
  import key_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg != stable_reg) begin
        // Accept the new level only after it has held for the full window.
        if (cnt_reg == CNT_LAST) begin
          stable_reg <= sync2_reg;
          cnt_reg    <= '0;
          press_reg  <= ~sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign press = press_reg;
  assign level = ~stable_reg;

endmodule

// File: rtl/key_step_controller.sv
// Free-run / stop / single-step / halt sequencer for the CPU clock-enable.
// Optional enabled-cycle counter: define KEY_STEP_CNT_EN.
module key_step_controller
  import key_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_step_n,
  input  logic        key_mode_n,
  input  logic        halt_in,
  output logic        cpu_en,
  output logic [1:0]  mode,
  output logic [15:0] instr_count
);

  localparam int KEY_STEP = 0;
  localparam int KEY_MODE = 1;

  logic [1:0] keys_n;
  logic [1:0] key_press;
  logic [1:0] unused_level;

  state_t state_reg;
  state_t state_next;

  assign keys_n = {key_mode_n, key_step_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk  (clk),
      .rst  (rst),
      .key_n(keys_n[gi]),
      .press(key_press[gi]),
      .level(unused_level[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_STOP;
    else      state_reg <= state_next;
  end

  // Mode key has priority over step key everywhere.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOP: begin
        if (key_press[KEY_MODE])      state_next = ST_RUN;
        else if (key_press[KEY_STEP]) state_next = halt_in ? ST_HALT : ST_STEP;
      end
      ST_STEP: state_next = ST_STOP;
      ST_RUN: begin
        if (key_press[KEY_MODE]) state_next = ST_STOP;
        else if (halt_in)        state_next = ST_HALT;
      end
      ST_HALT: begin
        if (key_press[KEY_MODE]) state_next = ST_STOP;
      end
      default: state_next = ST_STOP;
    endcase
  end

  assign cpu_en = (state_reg == ST_STEP) | ((state_reg == ST_RUN) & ~halt_in);
  assign mode   = mode_t'(state_reg);

`ifdef KEY_STEP_CNT_EN
  logic [15:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if ((state_reg == ST_HALT) && (state_next == ST_STOP)) begin
      count_reg <= '0;
    end else if (cpu_en) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign instr_count = count_reg;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_key_step_controller.sv
// Directed plus randomized bench for key_step_controller with a short debounce window.
module tb_key_step_controller;

  localparam int D = 4;
  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_STEP = 2'b01;
  localparam logic [1:0] M_RUN  = 2'b10;
  localparam logic [1:0] M_HALT = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_step_n = 1'b1;
  logic key_mode_n = 1'b1;
  logic halt_in = 1'b0;
  logic cpu_en;
  logic [1:0] mode;
  logic [15:0] instr_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model: index 0 = step key, 1 = mode key; history bit 0 = newest raw sample.
  logic [1:0]   m_mode = M_STOP;
  logic [15:0]  m_count = 16'h0000;
  logic [D+1:0] m_hist [2];
  logic         m_stable [2];
  logic         m_press [2];

  always #5 clk = ~clk;

  key_step_controller #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_step_n (key_step_n),
    .key_mode_n (key_mode_n),
    .halt_in    (halt_in),
    .cpu_en     (cpu_en),
    .mode       (mode),
    .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_STOP;
    m_count = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      m_hist[i]   = '1;
      m_stable[i] = 1'b1;
      m_press[i]  = 1'b0;
    end
  endtask

  function automatic logic model_en(input logic h);
    return (m_mode == M_STEP) || ((m_mode == M_RUN) && !h);
  endfunction

  // One clock edge: capture inputs, advance the model by the behavioural rules, compare.
  task automatic tick();
    logic       rst_s;
    logic       h;
    logic       en;
    logic       k [2];
    logic [1:0] nxt;
    rst_s = rst;
    h     = halt_in;
    k[0]  = key_step_n;
    k[1]  = key_mode_n;
    en    = model_en(h);
    @(posedge clk);
    if (!rst_s) begin
      model_reset();
    end else begin
      nxt = m_mode;
      if (m_mode == M_STOP) begin
        if (m_press[1])      nxt = M_RUN;
        else if (m_press[0]) nxt = h ? M_HALT : M_STEP;
      end else if (m_mode == M_STEP) begin
        nxt = M_STOP;
      end else if (m_mode == M_RUN) begin
        if (m_press[1]) nxt = M_STOP;
        else if (h)     nxt = M_HALT;
      end else begin
        if (m_press[1]) nxt = M_STOP;
      end
`ifdef KEY_STEP_CNT_EN
      if (m_mode == M_HALT && nxt == M_STOP) m_count = 16'h0000;
      else if (en)                           m_count = m_count + 16'd1;
`endif
      // A level is accepted once D consecutive synchronised samples disagree with it.
      for (int i = 0; i < 2; i++) begin
        m_hist[i]  = {m_hist[i][D:0], k[i]};
        m_press[i] = 1'b0;
        if (m_hist[i][D+1:2] == {D{~m_stable[i]}}) begin
          m_stable[i] = ~m_stable[i];
          m_press[i]  = !m_stable[i];
        end
      end
      m_mode = nxt;
    end
    #1;
    check("mode", 16'(mode), 16'(m_mode));
    check("cpu_en", 16'(cpu_en), 16'(model_en(halt_in)));
    check("instr_count", instr_count, m_count);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int dur;
    model_reset();

    // Reset, then a long mode press: STOP -> RUN.
    rst = 1'b0; ticks(2);
    rst = 1'b1; ticks(1);
    key_mode_n = 1'b0; ticks(10);
    check("run_after_mode_press", 16'(mode), 16'(M_RUN));
    check("run_cpu_en", 16'(cpu_en), 16'd1);
    key_mode_n = 1'b1; ticks(8);
    key_mode_n = 1'b0; ticks(8);
    key_mode_n = 1'b1; ticks(8);
    check("back_to_stop", 16'(mode), 16'(M_STOP));

    // Short glitch on the step key is filtered.
    key_step_n = 1'b0; ticks(3);
    key_step_n = 1'b1; ticks(10);
    check("glitch_stays_stop", 16'(mode), 16'(M_STOP));
    check("glitch_cpu_en", 16'(cpu_en), 16'd0);

    // Clean single step.
    key_step_n = 1'b0; ticks(10);
    key_step_n = 1'b1; ticks(8);
`ifdef KEY_STEP_CNT_EN
    check("one_step_count", instr_count, 16'd1);
`endif

    // RUN, then halt; halt release keeps HALT; mode press returns to STOP.
    key_mode_n = 1'b0; ticks(8);
    key_mode_n = 1'b1; ticks(6);
    halt_in = 1'b1; #1;
    check("halt_drops_en", 16'(cpu_en), 16'd0);
    ticks(1);
    check("halt_state", 16'(mode), 16'(M_HALT));
    halt_in = 1'b0; ticks(4);
    check("halt_sticky", 16'(mode), 16'(M_HALT));
    key_mode_n = 1'b0; ticks(8);
    key_mode_n = 1'b1; ticks(8);
    check("halt_exit", 16'(mode), 16'(M_STOP));

    // Simultaneous step and mode presses: mode wins.
    key_step_n = 1'b0; key_mode_n = 1'b0; ticks(10);
    check("simul_mode_wins", 16'(mode), 16'(M_RUN));
    key_step_n = 1'b1; key_mode_n = 1'b1; ticks(8);

    // Reset in RUN while step key is mid-debounce; key held through reset.
    key_step_n = 1'b0; ticks(3);
    rst = 1'b0; ticks(1);
    check("rst_mode", 16'(mode), 16'(M_STOP));
    check("rst_count", instr_count, 16'd0);
    rst = 1'b1; ticks(10);
    key_step_n = 1'b1; ticks(8);

    // Randomized segments of key/halt activity with occasional resets.
    for (int s = 0; s < 300; s++) begin
      key_step_n = ($urandom_range(0, 2) != 0);
      key_mode_n = ($urandom_range(0, 3) != 0);
      halt_in    = ($urandom_range(0, 4) == 0);
      rst        = ($urandom_range(0, 59) != 0);
      dur        = rst ? $urandom_range(1, 12) : $urandom_range(1, 2);
      ticks(dur);
      rst = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
